reg_wb_ctrl: RTL
================

Name: reg_wb_ctrl

Overview:
- Write-side master for the 32x32 register file: merges ALU results and variable-latency load returns from the data cache into the single register-file write port (WRITE/INADDRESS/IN).
- Load returns cannot stall and win the port; colliding ALU results are buffered in order in a small FIFO with backpressure.
- Keeps a pending-load scoreboard so the hazard unit can stall readers of registers still waiting on the cache.

Parameters:
- DEPTH, 4, ALU result FIFO entries (power of 2, >=2)
- AW, 2, FIFO pointer width, log2(DEPTH)

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset (0 = reset)
- ALU_VALID  in  1  ALU result offered this cycle
- ALU_RD  in  5  ALU destination register
- ALU_DATA  in  32  ALU result
- ALU_READY  out  1  ALU result accepted when ALU_VALID & ALU_READY
- LD_ISSUE  in  1  load issued to cache this cycle
- LD_RD  in  5  destination of the issued load
- MEM_VALID  in  1  load data returned (no backpressure)
- MEM_RD  in  5  destination of the returned load
- MEM_DATA  in  32  returned load data
- WRITE  out  1  register-file write enable (registered)
- INADDRESS  out  5  register-file write address (registered)
- IN  out  32  register-file write data (registered)
- BUSY_MASK  out  32  bit i = load to xi outstanding
- Q_COUNT  out  AW+1  ALU FIFO occupancy

Behaviour:
- Reset (RESET=0, async): WRITE=0, INADDRESS=0, IN=0, BUSY_MASK=0, FIFO empty (Q_COUNT=0), pointers 0. ALU_READY=1 from the first cycle after release. Reset mid-operation discards the FIFO and scoreboard.
- Per-cycle port source, first match wins:
  1. MEM_VALID & MEM_RD!=0 -> MEM
  2. FIFO non-empty -> FIFO head (popped)
  3. ALU accepted & ALU_RD!=0 -> ALU direct, bypassing the FIFO
  4. none -> WRITE=0 next cycle; INADDRESS/IN hold.
- The chosen source is registered onto WRITE/INADDRESS/IN at the next edge. Latency is exactly 1 cycle for MEM and for the bypass path.
- ALU acceptance:
  - ALU_READY = (Q_COUNT < DEPTH), combinational from registered count only.
  - Accepted result not chosen as source -> pushed at FIFO tail.
  - ALU_RD==0 -> accepted and dropped; never enqueued, never written.
- MEM_RD==0 -> dropped; does not block the port, so the FIFO may drain that cycle.
- Ordering: ALU results reach the register file in acceptance order. Bypass happens only when the FIFO is empty.
- Push and pop in the same cycle -> count unchanged. Pointers wrap modulo DEPTH.
- Scoreboard:
  - LD_ISSUE & LD_RD!=0 sets BUSY_MASK[LD_RD] at the next edge.
  - MEM_VALID clears BUSY_MASK[MEM_RD] at the next edge.
  - Set and clear of the same bit in one cycle -> set wins, because a new load is outstanding.
  - BUSY_MASK[0] is always 0.
  - MEM return for a non-busy register is still written; the mask is unchanged.
- Once accepted, no ALU result is ever lost. Continuous MEM traffic may starve the FIFO; ALU_READY then stays low until it drains.

Decomposition:
- Shared package: REG_ADDR_W=5, XLEN=32, REG_ZERO=5'd0, source-select enum {SRC_NONE, SRC_MEM, SRC_FIFO, SRC_ALU}.
- Sub-module wb_fifo: DEPTH x (5+32) synchronous FIFO with push, pop, count, head. Same CLK and active-low async RESET.

Test Plan:
- ALU_VALID, ALU_RD=5, ALU_DATA=0x11, FIFO empty, no MEM -> next cycle WRITE=1, INADDRESS=5, IN=0x11; Q_COUNT stays 0.
- MEM_VALID rd=3 data=0xAA with ALU_VALID rd=4 data=0xBB in the same cycle -> cycle+1 writes x3=0xAA, cycle+2 writes x4=0xBB; Q_COUNT peaks at 1.
- MEM_VALID every cycle plus 5 ALU offers -> ALU_READY drops after 4 accepts (Q_COUNT=4). When MEM stops, 4 writes follow in acceptance order.
- LD_ISSUE rd=7 -> BUSY_MASK=0x80. Then LD_ISSUE rd=7 together with MEM_VALID rd=7 -> mask stays 0x80. Next MEM rd=7 -> mask 0.
- ALU_RD=0 or MEM_RD=0 offers -> WRITE never asserted, FIFO unchanged. LD_ISSUE rd=0 -> BUSY_MASK stays 0.
- Fill FIFO to 3, assert RESET=0 mid-cycle -> WRITE/IN/INADDRESS/BUSY_MASK/Q_COUNT=0 immediately. After release, no stale writes appear.

Source files
------------

// File: rtl/reg_wb_ctrl_pkg.sv
// Shared types for the register-file write-back path.
// Holds widths, the write-back entry type and the source-select enum.
package reg_wb_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_MEM,
        SRC_FIFO,
        SRC_ALU
    } src_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_ent_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer for ALU results that lost the write port.
// Ports: CLK, RESET (async low), i_push/i_data, i_pop, o_head, o_count.
module wb_fifo
    import reg_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          i_push,
    input  wb_ent_t       i_data,
    input  logic          i_pop,
    output wb_ent_t       o_head,
    output logic [AW:0]   o_count
);

    wb_ent_t       r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    // Payload storage needs no reset; validity lives in r_count.
    always_ff @(posedge CLK) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers are exactly AW bits, so they wrap modulo DEPTH.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write-port master: arbitrates load returns, buffered
// and direct ALU results, and tracks outstanding loads per register.
// Ports: CLK/RESET, ALU_* handshake, LD_* issue, MEM_* return,
// WRITE/INADDRESS/IN to the register file, BUSY_MASK, Q_COUNT.
module reg_wb_ctrl
    import reg_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ALU_VALID,
    input  logic [REG_ADDR_W-1:0] ALU_RD,
    input  logic [XLEN-1:0]       ALU_DATA,
    output logic                  ALU_READY,
    input  logic                  LD_ISSUE,
    input  logic [REG_ADDR_W-1:0] LD_RD,
    input  logic                  MEM_VALID,
    input  logic [REG_ADDR_W-1:0] MEM_RD,
    input  logic [XLEN-1:0]       MEM_DATA,
    output logic                  WRITE,
    output logic [REG_ADDR_W-1:0] INADDRESS,
    output logic [XLEN-1:0]       IN,
    output logic [XLEN-1:0]       BUSY_MASK,
    output logic [AW:0]           Q_COUNT
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic                  r_write;
    logic [REG_ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]       r_data;
    logic [XLEN-1:0]       r_busy;

    logic        w_acc;
    logic        w_alu_wr;
    logic        w_mem_wr;
    logic        w_push;
    logic        w_pop;
    src_e        w_src;
    wb_ent_t     w_head;
    wb_ent_t     w_alu_ent;
    logic [AW:0] w_count;
    logic [XLEN-1:0] w_set;
    logic [XLEN-1:0] w_clr;

    assign ALU_READY = (w_count < DEPTH_C);
    assign w_acc     = ALU_VALID & ALU_READY;
    assign w_alu_wr  = w_acc & (ALU_RD != REG_ZERO);
    assign w_mem_wr  = MEM_VALID & (MEM_RD != REG_ZERO);
    assign w_alu_ent = '{rd: ALU_RD, data: ALU_DATA};

    always_comb begin
        w_src = SRC_NONE;
        if (w_mem_wr) begin
            w_src = SRC_MEM;
        end else if (w_count != '0) begin
            w_src = SRC_FIFO;
        end else if (w_alu_wr) begin
            w_src = SRC_ALU;
        end
    end

    // Bypass only wins when the FIFO is empty, preserving ALU order.
    assign w_pop  = (w_src == SRC_FIFO);
    assign w_push = w_alu_wr & (w_src != SRC_ALU);

    wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_push  (w_push),
        .i_data  (w_alu_ent),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            unique case (w_src)
                SRC_MEM: begin
                    r_write <= 1'b1;
                    r_addr  <= MEM_RD;
                    r_data  <= MEM_DATA;
                end
                SRC_FIFO: begin
                    r_write <= 1'b1;
                    r_addr  <= w_head.rd;
                    r_data  <= w_head.data;
                end
                SRC_ALU: begin
                    r_write <= 1'b1;
                    r_addr  <= ALU_RD;
                    r_data  <= ALU_DATA;
                end
                default: begin
                    r_write <= 1'b0;
                end
            endcase
        end
    end

    // Set is OR-ed after clear: a re-issued load stays outstanding.
    assign w_set = (LD_ISSUE && LD_RD != REG_ZERO)
                 ? (XLEN'(1) << LD_RD) : '0;
    assign w_clr = MEM_VALID ? (XLEN'(1) << MEM_RD) : '0;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_clr) | w_set) & ~XLEN'(1);
        end
    end

    assign WRITE     = r_write;
    assign INADDRESS = r_addr;
    assign IN        = r_data;
    assign BUSY_MASK = r_busy;
    assign Q_COUNT   = w_count;

endmodule
